// File: rtl/muldiv_unit_pkg.sv
// Shared op codes, FSM state encodings and operand-sign helpers for the RV32M/RV64M multiply/divide unit.
package muldiv_unit_pkg;
   localparam logic [2:0] MD_MUL    = 3'd0;
   localparam logic [2:0] MD_MULH   = 3'd1;
   localparam logic [2:0] MD_MULHSU = 3'd2;
   localparam logic [2:0] MD_MULHU  = 3'd3;
   localparam logic [2:0] MD_DIV    = 3'd4;
   localparam logic [2:0] MD_DIVU   = 3'd5;
   localparam logic [2:0] MD_REM    = 3'd6;
   localparam logic [2:0] MD_REMU   = 3'd7;

   localparam logic [1:0] MD_IDLE = 2'd0;
   localparam logic [1:0] MD_BUSY = 2'd1;
   localparam logic [1:0] MD_DONE = 2'd2;

   function automatic logic op_a_signed(input logic [2:0] op);
      return (op == MD_MULH) || (op == MD_MULHSU) || (op == MD_DIV) || (op == MD_REM);
   endfunction

   function automatic logic op_b_signed(input logic [2:0] op);
      return (op == MD_MULH) || (op == MD_DIV) || (op == MD_REM);
   endfunction
endpackage

// File: rtl/muldiv_unit_if.sv
// Request/response handshake bundle between the EX stage and the multiply/divide unit.
interface muldiv_unit_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [XLEN-1:0]  a;
   logic [XLEN-1:0]  b;
   logic [TAG_W-1:0] in_tag;
   logic             flush;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  result;
   logic [TAG_W-1:0] out_tag;
   logic             busy;

   modport master (
      output in_valid, op, a, b, in_tag, flush, out_ready,
      input  in_ready, out_valid, result, out_tag, busy
   );

   modport slave (
      input  in_valid, op, a, b, in_tag, flush, out_ready,
      output in_ready, out_valid, result, out_tag, busy
   );
endinterface

// File: rtl/md_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor, keep or restore.
module md_div_step #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic            dividend_bit_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN-1:0] rem_o,
   output logic            q_bit_o
);
   logic [XLEN:0] rem_sh;
   logic [XLEN:0] diff;

   // rem_i < divisor always holds, so the shifted value fits XLEN+1 bits and diff's MSB is the borrow
   assign rem_sh  = {rem_i, dividend_bit_i};
   assign diff    = rem_sh - {1'b0, divisor_i};
   assign q_bit_o = ~diff[XLEN];
   assign rem_o   = q_bit_o ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: unsigned shift-add / restoring-divide core on operand magnitudes,
// sign fix-up on entry to DONE, and a single-cycle path for divide-by-zero and signed overflow.
//   state   | meaning
//   MD_IDLE | ready for a request
//   MD_BUSY | iterating, BITS_PER_CYCLE bits per cycle
//   MD_DONE | result valid, held until out_ready
module muldiv_unit
   import muldiv_unit_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1,
   parameter int TAG_W          = 5
) (
   input logic          clk,
   input logic          reset,
   muldiv_unit_if.slave bus
);
   localparam int               ITERS    = XLEN / BITS_PER_CYCLE;
   localparam int               CW       = $clog2(ITERS) + 1;
   localparam logic [CW-1:0]    CNT_LAST = CW'(ITERS - 1);
   localparam logic [CW-1:0]    CNT_MAX  = CW'(ITERS);
   localparam logic [XLEN-1:0]  MIN_VAL  = {1'b1, {(XLEN-1){1'b0}}};

   logic [1:0]       state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [XLEN-1:0]  hi_q, hi_d;
   logic [XLEN-1:0]  lo_q, lo_d;
   logic [XLEN-1:0]  opb_q, opb_d;
   logic [XLEN-1:0]  result_q, result_d;
   logic             neg_q, neg_d;
   logic             rneg_q, rneg_d;

   // Restoring divide chain: hi holds the partial remainder, lo shifts dividend out / quotient in
   for (genvar i = 0; i < BITS_PER_CYCLE; i++) begin : g_step
      logic [XLEN-1:0] rem_in, quo_in, rem_out, quo_out;
      logic            q_bit;
      if (i == 0) begin : g_first
         assign rem_in = hi_q;
         assign quo_in = lo_q;
      end else begin : g_next
         assign rem_in = g_step[i-1].rem_out;
         assign quo_in = g_step[i-1].quo_out;
      end
      md_div_step #(.XLEN(XLEN)) u_div_step (
         .rem_i          (rem_in),
         .dividend_bit_i (quo_in[XLEN-1]),
         .divisor_i      (opb_q),
         .rem_o          (rem_out),
         .q_bit_o        (q_bit)
      );
      assign quo_out = {quo_in[XLEN-2:0], q_bit};
   end

   logic [XLEN-1:0] mul_hi, mul_lo;
   always_comb begin
      logic [XLEN:0] sum;
      mul_hi = hi_q;
      mul_lo = lo_q;
      sum    = '0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         sum    = {1'b0, mul_hi} + (mul_lo[0] ? {1'b0, opb_q} : '0);
         mul_lo = {sum[0], mul_lo[XLEN-1:1]};
         mul_hi = sum[XLEN:1];
      end
   end

   logic [XLEN-1:0]   step_hi, step_lo, fin_res;
   logic [2*XLEN-1:0] prod_s;
   assign step_hi = op_q[2] ? g_step[BITS_PER_CYCLE-1].rem_out : mul_hi;
   assign step_lo = op_q[2] ? g_step[BITS_PER_CYCLE-1].quo_out : mul_lo;
   assign prod_s  = neg_q ? -{step_hi, step_lo} : {step_hi, step_lo};

   always_comb begin
      unique case (op_q)
         MD_MUL:                       fin_res = prod_s[XLEN-1:0];
         MD_MULH, MD_MULHSU, MD_MULHU: fin_res = prod_s[2*XLEN-1:XLEN];
         MD_DIV, MD_DIVU:              fin_res = neg_q ? -step_lo : step_lo;
         MD_REM, MD_REMU:              fin_res = rneg_q ? -step_hi : step_hi;
      endcase
   end

   logic            a_neg, b_neg, div_zero, div_ovf;
   logic [XLEN-1:0] a_mag, b_mag, fast_res;
   assign a_neg    = op_a_signed(bus.op) & bus.a[XLEN-1];
   assign b_neg    = op_b_signed(bus.op) & bus.b[XLEN-1];
   assign a_mag    = a_neg ? -bus.a : bus.a;
   assign b_mag    = b_neg ? -bus.b : bus.b;
   assign div_zero = bus.op[2] && (bus.b == '0);
   assign div_ovf  = ((bus.op == MD_DIV) || (bus.op == MD_REM)) && (bus.a == MIN_VAL) && (bus.b == '1);
   // op[1] separates REM/REMU from DIV/DIVU
   assign fast_res = div_zero ? (bus.op[1] ? bus.a : '1) : (bus.op[1] ? '0 : MIN_VAL);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      op_d     = op_q;
      tag_d    = tag_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      opb_d    = opb_q;
      result_d = result_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      case (state_q)
         MD_IDLE: begin
            if (bus.in_valid && !bus.flush) begin
               op_d   = bus.op;
               tag_d  = bus.in_tag;
               neg_d  = a_neg ^ b_neg;
               rneg_d = a_neg;
               hi_d   = '0;
               lo_d   = bus.op[2] ? a_mag : b_mag;
               opb_d  = bus.op[2] ? b_mag : a_mag;
               cnt_d  = '0;
               if (div_zero || div_ovf) begin
                  result_d = fast_res;
                  state_d  = MD_DONE;
               end else begin
                  state_d = MD_BUSY;
               end
            end
         end
         MD_BUSY: begin
            hi_d = step_hi;
            lo_d = step_lo;
            if (cnt_q == CNT_LAST) begin
               cnt_d    = CNT_MAX;
               result_d = fin_res;
               state_d  = MD_DONE;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         MD_DONE: begin
            if (bus.out_ready) state_d = MD_IDLE;
         end
         default: state_d = MD_IDLE;
      endcase
      if (bus.flush) state_d = MD_IDLE;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= MD_IDLE;
         cnt_q    <= '0;
         op_q     <= '0;
         tag_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         opb_q    <= '0;
         result_q <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         op_q     <= op_d;
         tag_q    <= tag_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         opb_q    <= opb_d;
         result_q <= result_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
      end
   end

   assign bus.in_ready  = (state_q == MD_IDLE);
   assign bus.out_valid = (state_q == MD_DONE);
   assign bus.busy      = (state_q != MD_IDLE);
   assign bus.result    = result_q;
   assign bus.out_tag   = tag_q;
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised, multi-cycle RV32M/RV64M multiply/divide unit. It is the successor to the single-cycle combinational ALU.
- Sits beside the ALU in the EX stage. The pipeline stalls on `in_ready`/`out_valid`.
- Iterative engine retires `BITS_PER_CYCLE` quotient/multiplier bits per cycle.
- Valid/ready handshake on both sides, a destination tag, flush support, and a fast path for division corner cases.

Parameters:
- `XLEN`, 32, operand/result width; 32 or 64.
- `BITS_PER_CYCLE`, 1, bits processed per iteration; 1, 2 or 4; must divide `XLEN`.
- `TAG_W`, 5, width of the pass-through tag (rd index).

Ports:
- `clk` input 1: core clock, rising edge.
- `reset` input 1: synchronous, active-high reset.
- `in_valid` input 1: request valid.
- `in_ready` output 1: unit can accept a request; high only in IDLE.
- `op` input 3: funct3 of the M instruction. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `a` input XLEN: rs1 operand.
- `b` input XLEN: rs2 operand.
- `in_tag` input TAG_W: tag carried to the output.
- `flush` input 1: abort any in-flight or completed op.
- `out_valid` output 1: result valid.
- `out_ready` input 1: consumer accepts result.
- `result` output XLEN: result.
- `out_tag` output TAG_W: tag of the result.
- `busy` output 1: state != IDLE.

Behaviour:
- Reset (synchronous, active-high):
  - state=IDLE.
  - `out_valid`=0, `result`=0, `out_tag`=0, `busy`=0, `in_ready`=1.
  - All internal registers are cleared.
- States:
  - IDLE to BUSY on `in_valid`&&`in_ready` (normal case).
  - IDLE to DONE on `in_valid`&&`in_ready` when a fast-path case applies.
  - BUSY to DONE when the iteration counter reaches `XLEN/BITS_PER_CYCLE`.
  - DONE to IDLE on `out_ready`.
- Accept cycle: `op`, `a`, `b` and `in_tag` are latched in the accept cycle and need not be held afterwards.
- Latency: with the accept cycle as cycle 0, `out_valid` first rises in cycle `XLEN/BITS_PER_CYCLE`+1 (33 for defaults). The fast path raises it in cycle 1.
- Sign handling:
  - Signed operands: DIV/REM both operands, MULH both operands, MULHSU `a` only.
  - These are converted to magnitudes on accept. The iteration is unsigned.
  - Final negation is applied on entry to DONE.
- Multiply: a 2*XLEN-bit product is formed by shift-add. MUL returns the low XLEN bits; MULH/MULHSU/MULHU return the high XLEN bits.
- Divide: restoring division on magnitudes.
  - Quotient sign = sign(a) XOR sign(b).
  - Remainder takes the sign of the dividend. Truncation is toward zero.
- Fast path (no iteration):
  - Divide by zero: DIV/DIVU quotient = all ones; REM/REMU = `a`.
  - Signed overflow (`a`=MIN, `b`=-1): DIV = MIN; REM = 0.
- Output hold: `result`/`out_tag` are held stable while `out_valid`&&!`out_ready`. No new request is accepted until the handshake completes (`in_ready`=0 in DONE).
- Flush:
  - `flush` in any state forces IDLE on the next edge and drops `out_valid`. The result is discarded.
  - `flush` with `in_valid` in IDLE: the request is not accepted.
  - `flush` has priority over `out_ready` and `in_valid`.
- Reset mid-operation: behaves as reset; no result is emitted.
- Back-to-back operation: `out_ready` in DONE returns to IDLE. The next request can be accepted in the following cycle. There is no same-cycle accept-and-complete.
- Counter: `$clog2(XLEN/BITS_PER_CYCLE)+1` bits wide. It does not wrap; it saturates until the state changes.

Decomposition:
- Add to `xgriscv_defines.v`:
  - `MD_MUL`..`MD_REMU` 3-bit op codes.
  - State encodings `MD_IDLE`=2'd0, `MD_BUSY`=2'd1, `MD_DONE`=2'd2.
- Sub-module `md_div_step`: combinational single-bit restoring step (remainder, divisor, next quotient bit). Instantiated `BITS_PER_CYCLE` times in a chain.
- The multiply step is inline.

Test Plan:
- MUL `a`=7, `b`=0xFFFFFFFD (-3): `result`=0xFFFFFFEB, `out_valid` in cycle 33, `out_tag` = `in_tag`.
- MULH 0x80000000×0x80000000: 0x40000000. MULHSU `a`=0xFFFFFFFF, `b`=0xFFFFFFFF: 0xFFFFFFFF. MULHU same operands: 0xFFFFFFFE.
- DIV `a`=0xFFFFFFF9 (-7), `b`=2: 0xFFFFFFFD. REM same operands: 0xFFFFFFFF. DIVU 100/7: 14. REMU 100/7: 2.
- DIVU `a`=0x1234, `b`=0: 0xFFFFFFFF in cycle 1. REMU same operands: 0x1234. DIV 0x80000000 / 0xFFFFFFFF: 0x80000000 in cycle 1. REM same operands: 0.
- Backpressure: `out_ready`=0 for 5 cycles after `out_valid`. `result` must be stable, `in_ready`=0 and `in_valid` ignored; completes on `out_ready`=1.
- `flush` in cycle 10 of a DIV: IDLE and `in_ready`=1 next cycle, no `out_valid`. A following MUL 3×4 returns 12. Repeat with `reset` mid-BUSY: same outcome.
